// File: rtl/register_bank.sv
// ---------------------------------------------------------------------------
// register_bank
//
// Multi-port register file for the ID stage. One write port, NR registered
// read ports and one registered debug read port. A write accepted at an edge
// is forwarded straight to any read port addressing the same entry at that
// edge (write-through). When ZERO_REG is set, entry 0 always reads as zero
// and writes to it are dropped.
//
// After reset a clear sequencer walks every entry to zero and holds o_ready
// low until the whole array is initialised. The array itself has no reset;
// only the sequencer, the FSM and the output registers do.
//
// Ports
//   i_clk             clock, rising edge
//   i_reset_n         synchronous active-low reset
//   i_reg_write_MC    write enable (RegWrite from WB)
//   i_write_register  write address
//   i_write_data      write data
//   i_read_regs       NR packed read addresses, port k at [k*W +: W]
//   i_dbg_addr        debug read address
//   o_read_data       NR packed read data, port k at [k*B +: B]
//   o_dbg_data        debug read data
//   o_ready           array initialised, writes accepted
// ---------------------------------------------------------------------------
module register_bank #(
  parameter int B              = 32,
  parameter int W              = 5,
  parameter int NR             = 2,
  parameter int ZERO_REG       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_reg_write_MC,
  input  logic [W-1:0]    i_write_register,
  input  logic [B-1:0]    i_write_data,
  input  logic [NR*W-1:0] i_read_regs,
  input  logic [W-1:0]    i_dbg_addr,
  output logic [NR*B-1:0] o_read_data,
  output logic [B-1:0]    o_dbg_data,
  output logic            o_ready
);

  localparam int           DEPTH     = 1 << W;
  localparam logic [W-1:0] LAST_ADDR = W'(DEPTH - 1);
  localparam bit           HAS_ZERO  = (ZERO_REG != 0);
  localparam bit           DO_CLEAR  = (CLEAR_ON_RESET != 0);

  // The debug port is handled as one extra read port appended after the
  // NR architectural ports, so all ports share exactly the same rules.
  localparam int NP = NR + 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t         state_reg;
  logic [W-1:0]   cnt_reg;
  logic           ready_reg;

  logic [B-1:0]   mem [DEPTH];

  logic           wr_accept;
  logic           clear_we;
  logic           mem_we;
  logic [W-1:0]   mem_waddr;
  logic [B-1:0]   mem_wdata;

  logic [NP*W-1:0] port_addr;
  logic [NP*B-1:0] port_data;

  // -------------------------------------------------------------------------
  // Write-side decode. Architectural writes are only honoured once the array
  // has been initialised; the sequencer owns the write port while clearing.
  // -------------------------------------------------------------------------
  always_comb begin
    wr_accept = i_reset_n && (state_reg == ST_READY) && i_reg_write_MC &&
                !(HAS_ZERO && (i_write_register == '0));
    clear_we  = i_reset_n && (state_reg == ST_CLEAR) && DO_CLEAR;
    mem_we    = wr_accept || clear_we;
    mem_waddr = clear_we ? cnt_reg : i_write_register;
    mem_wdata = clear_we ? '0      : i_write_data;
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Clear sequencer / readiness FSM.
  // The edge that clears the last entry is also the edge that raises o_ready,
  // so o_ready is first seen high after DEPTH released edges.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          if (DO_CLEAR) begin
            cnt_reg <= cnt_reg + W'(1);
            if (cnt_reg == LAST_ADDR) begin
              state_reg <= ST_READY;
              ready_reg <= 1'b1;
            end
          end else begin
            state_reg <= ST_READY;
            ready_reg <= 1'b1;
          end
        end
        ST_READY: begin
          state_reg <= ST_READY;
          ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_CLEAR;
          cnt_reg   <= '0;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready = ready_reg;

  // -------------------------------------------------------------------------
  // Read ports (architectural ports followed by the debug port).
  // Priority, lowest to highest: stored value, same-edge bypass, hardwired
  // zero, not-ready. The zero override beats the bypass so a dropped write
  // to entry 0 can never leak through.
  // -------------------------------------------------------------------------
  assign port_addr = {i_dbg_addr, i_read_regs};

  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_port
      logic [W-1:0] addr;
      logic [B-1:0] data_next;
      logic [B-1:0] data_reg;

      assign addr = port_addr[gi*W +: W];

      always_comb begin
        data_next = mem[addr];
        if (wr_accept && (addr == i_write_register)) begin
          data_next = i_write_data;
        end
        if (HAS_ZERO && (addr == '0)) begin
          data_next = '0;
        end
        if (state_reg != ST_READY) begin
          data_next = '0;
        end
      end

      always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
          data_reg <= '0;
        end else begin
          data_reg <= data_next;
        end
      end

      assign port_data[gi*B +: B] = data_reg;
    end
  endgenerate

  assign o_read_data = port_data[NR*B-1:0];
  assign o_dbg_data  = port_data[NR*B +: B];

endmodule

// File: tb/tb_register_bank.sv
// ---------------------------------------------------------------------------
// tb_register_bank
//
// Two register_bank instances side by side:
//   A: NR=2, ZERO_REG=1, CLEAR_ON_RESET=1
//   B: NR=3, ZERO_REG=1, CLEAR_ON_RESET=0
// The driver applies inputs on the falling edge, asks a behavioural model
// what each instance must show after the next rising edge and queues it.
// A monitor pops one expectation per instance per rising edge and compares.
// The model tracks readiness by counting released edges and keeps a plain
// array of register values; entries never written in B are "unknown" and
// their read results are not compared.
// ---------------------------------------------------------------------------
module tb_register_bank;

  localparam int B     = 32;
  localparam int W     = 5;
  localparam int DEPTH = 32;

  typedef struct {
    logic         ready;
    logic [127:0] rd;
    logic [3:0]   chk;
    logic [31:0]  dbg;
    logic         dchk;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus, index 0 = instance A, 1 = instance B
  logic         rstn [2];
  logic         we   [2];
  logic [4:0]   wa   [2];
  logic [31:0]  wd   [2];
  logic [4:0]   ra   [2][4];
  logic [4:0]   dbg  [2];

  logic [9:0]   ra_bus_a;
  logic [14:0]  ra_bus_b;
  logic [63:0]  rd_a;
  logic [95:0]  rd_b;
  logic [31:0]  dbgd_a, dbgd_b;
  logic         rdy_a, rdy_b;

  assign ra_bus_a = {ra[0][1], ra[0][0]};
  assign ra_bus_b = {ra[1][2], ra[1][1], ra[1][0]};

  register_bank #(.B(B), .W(W), .NR(2), .ZERO_REG(1), .CLEAR_ON_RESET(1)) u_dut_a (
    .i_clk            (clk),
    .i_reset_n        (rstn[0]),
    .i_reg_write_MC   (we[0]),
    .i_write_register (wa[0]),
    .i_write_data     (wd[0]),
    .i_read_regs      (ra_bus_a),
    .i_dbg_addr       (dbg[0]),
    .o_read_data      (rd_a),
    .o_dbg_data       (dbgd_a),
    .o_ready          (rdy_a)
  );

  register_bank #(.B(B), .W(W), .NR(3), .ZERO_REG(1), .CLEAR_ON_RESET(0)) u_dut_b (
    .i_clk            (clk),
    .i_reset_n        (rstn[1]),
    .i_reg_write_MC   (we[1]),
    .i_write_register (wa[1]),
    .i_write_data     (wd[1]),
    .i_read_regs      (ra_bus_b),
    .i_dbg_addr       (dbg[1]),
    .o_read_data      (rd_b),
    .o_dbg_data       (dbgd_b),
    .o_ready          (rdy_b)
  );

  // ------------------------------------------------------------------ model
  logic [31:0] mem_m      [2][DEPTH];
  bit          known_m    [2][DEPTH];
  int          released_m [2];
  bit          ready_m    [2];
  int          nr_m   [2] = '{2, 3};
  int          need_m [2] = '{DEPTH, 1};
  bit          clr_m  [2] = '{1'b1, 1'b0};

  exp_t q_a [$];
  exp_t q_b [$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic read_rule(input int n, input logic [4:0] a, input logic acc,
                           output logic [31:0] v, output logic ok);
    ok = 1'b1;
    if (a == 5'd0) begin
      v = 32'd0;
    end else if (acc && (a == wa[n])) begin
      v = wd[n];
    end else begin
      v  = mem_m[n][a];
      ok = known_m[n][a];
    end
  endtask

  task automatic model_step(input int n, output exp_t e);
    logic        acc;
    logic [31:0] v;
    logic        ok;
    e.ready = 1'b0;
    e.rd    = '0;
    e.chk   = '1;
    e.dbg   = 32'd0;
    e.dchk  = 1'b1;
    e.cyc   = cyc;
    if (!rstn[n]) begin
      released_m[n] = 0;
      ready_m[n]    = 1'b0;
    end else if (ready_m[n]) begin
      acc = we[n] && (wa[n] != 5'd0);
      for (int k = 0; k < nr_m[n]; k++) begin
        read_rule(n, ra[n][k], acc, v, ok);
        e.rd[k*32 +: 32] = v;
        e.chk[k]         = ok;
      end
      read_rule(n, dbg[n], acc, v, ok);
      e.dbg  = v;
      e.dchk = ok;
      if (acc) begin
        mem_m[n][wa[n]]   = wd[n];
        known_m[n][wa[n]] = 1'b1;
      end
      e.ready = 1'b1;
    end else begin
      released_m[n]++;
      if (released_m[n] >= need_m[n]) begin
        ready_m[n] = 1'b1;
        if (clr_m[n]) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem_m[n][i]   = 32'd0;
            known_m[n][i] = 1'b1;
          end
        end
      end
      e.ready = ready_m[n];
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step();
    exp_t ea, eb;
    model_step(0, ea);
    model_step(1, eb);
    q_a.push_back(ea);
    q_b.push_back(eb);
    $display("T%0d A rst=%0b we=%0b wa=%0d wd=%h ra=%0d,%0d dbg=%0d | B rst=%0b we=%0b wa=%0d wd=%h ra=%0d,%0d,%0d dbg=%0d",
             cyc, rstn[0], we[0], wa[0], wd[0], ra[0][0], ra[0][1], dbg[0],
             rstn[1], we[1], wa[1], wd[1], ra[1][0], ra[1][1], ra[1][2], dbg[1]);
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    we[n]  = 1'b0;
    wa[n]  = 5'd0;
    wd[n]  = 32'd0;
    dbg[n] = 5'd0;
    for (int k = 0; k < 4; k++) ra[n][k] = 5'd0;
  endtask

  task automatic randomize_inst(input int n, input bit wide);
    we[n]  = ($urandom_range(0, 1) == 1);
    wa[n]  = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    wd[n]  = $urandom;
    dbg[n] = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    for (int k = 0; k < 4; k++)
      ra[n][k] = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endtask

  // ---------------------------------------------------------------- monitor
  task automatic cmp(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at T%0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        cmp("A ready", e.cyc, {31'd0, rdy_a}, {31'd0, e.ready});
        for (int k = 0; k < 2; k++)
          if (e.chk[k]) cmp($sformatf("A rd%0d", k), e.cyc, rd_a[k*32 +: 32], e.rd[k*32 +: 32]);
        if (e.dchk) cmp("A dbg", e.cyc, dbgd_a, e.dbg);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        cmp("B ready", e.cyc, {31'd0, rdy_b}, {31'd0, e.ready});
        for (int k = 0; k < 3; k++)
          if (e.chk[k]) cmp($sformatf("B rd%0d", k), e.cyc, rd_b[k*32 +: 32], e.rd[k*32 +: 32]);
        if (e.dchk) cmp("B dbg", e.cyc, dbgd_b, e.dbg);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    for (int n = 0; n < 2; n++) begin
      rstn[n] = 1'b0;
      ready_m[n] = 1'b0;
      released_m[n] = 0;
      idle(n);
      for (int i = 0; i < DEPTH; i++) begin
        mem_m[n][i]   = 32'd0;
        known_m[n][i] = 1'b0;
      end
    end
    @(negedge clk);

    // reset for 3 cycles
    repeat (3) step();

    // release; A clears for 32 edges, B becomes ready after one edge
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      randomize_inst(0, 1'b1);           // A: writes must be ignored
      idle(1);
      case (i)
        1: begin we[1] = 1'b1; wa[1] = 5'd1;  wd[1] = 32'd1;  end
        2: begin we[1] = 1'b1; wa[1] = 5'd2;  wd[1] = 32'd2;  end
        3: begin we[1] = 1'b1; wa[1] = 5'd31; wd[1] = 32'd31; end
        4: begin ra[1][0] = 5'd1; ra[1][1] = 5'd2; ra[1][2] = 5'd31; end
        default: ;
      endcase
      step();
    end

    // debug sweep of every entry in A after the clear
    idle(0);
    for (int a = 0; a < DEPTH; a++) begin
      dbg[0]   = 5'(a);
      ra[0][0] = 5'(a);
      ra[0][1] = 5'(DEPTH - 1 - a);
      step();
    end

    // write r7 then read it on both ports
    idle(0);
    we[0] = 1'b1; wa[0] = 5'd7; wd[0] = 32'hDEADBEEF;
    step();
    idle(0);
    ra[0][0] = 5'd7; ra[0][1] = 5'd7;
    step();
    step();

    // same-edge write-through to port 1
    idle(0);
    ra[0][0] = 5'd7;
    we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h12345678; ra[0][1] = 5'd3; dbg[0] = 5'd3;
    step();
    idle(0);
    ra[0][1] = 5'd3;
    step();

    // write to r0 is dropped and never visible
    idle(0);
    we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'hFFFFFFFF; ra[0][0] = 5'd0; dbg[0] = 5'd0;
    step();
    idle(0);
    repeat (3) step();

    // reset mid-clear at count 10, then a write during the new clear
    idle(0);
    rstn[0] = 1'b0;
    step();
    rstn[0] = 1'b1;
    repeat (10) step();
    rstn[0] = 1'b0;
    step();
    rstn[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      idle(0);
      if (i == 3) begin we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hAA; end
      randomize_inst(1, 1'b0);
      step();
    end
    idle(0);
    ra[0][0] = 5'd5; ra[0][1] = 5'd5; dbg[0] = 5'd5;
    repeat (2) step();

    // randomized traffic with frequent address collisions
    for (int i = 0; i < 200; i++) begin
      randomize_inst(0, (i % 4) == 0);
      randomize_inst(1, (i % 4) == 1);
      step();
    end

    idle(0);
    idle(1);
    step();
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ((q_a.size() != 0) || (q_b.size() != 0)) begin
      errors++;
      $display("FAIL drain: pending A %0d B %0d expected 0", q_a.size(), q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
